fp_add_norm_ctrl: RTL and testbench
===================================

Name: fp_add_norm_ctrl

Overview:
Multi-cycle normalization sequencer for the FP adder. It sits between the significand adder and the rounding stage.
- Accepts one raw sum per transaction: significand, carry-out, exponent, sign.
- Handles carry-out with a single sticky right shift.
- Otherwise left-normalizes one bit per cycle until the hidden bit is set, a zero result is found, or the exponent floor is reached.
- Presents the normalized result on a valid/ready output.

Parameters:
MANT_W, 27, significand width; bit MANT_W-1 is the hidden-bit position, bit 0 is sticky.
EXP_W, 8, biased exponent width; EXP_MAX = 2^EXP_W-1 encodes Inf.
CNT_W, 5, shift-count width; must satisfy 2^CNT_W > MANT_W-1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  raw sum valid
in_ready  out  1  controller can accept
in_mant  in  MANT_W  adder significand output
in_ovf  in  1  adder carry-out
in_exp  in  EXP_W  pre-normalization biased exponent
in_sign  in  1  result sign, passed through
out_valid  out  1  normalized result valid
out_ready  in  1  rounding stage accepts
out_mant  out  MANT_W  normalized significand
out_exp  out  EXP_W  adjusted exponent
out_sign  out  1  captured sign
out_shift  out  CNT_W  number of left shifts applied
out_zero  out  1  result is exactly zero
out_inf  out  1  exponent overflow; out_mant forced to 0
out_denorm  out  1  exponent floor hit before hidden bit set

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. Asserting rst forces state IDLE and clears all output registers to 0. in_ready=1 in IDLE after reset.
- Reset mid-NORM or mid-DONE abandons the transaction; nothing is emitted.
- States: IDLE, NORM, DONE.
- in_ready=1 only in IDLE; there is no overlap between transactions.
- out_valid=1 only in DONE.

- IDLE, accept (in_valid & in_ready): capture the operands, clear the flags and out_shift, then resolve in this priority order:
  1. in_ovf=1: mant <= {1, in_mant[MANT_W-1:2], in_mant[1]|in_mant[0]}; exp <= in_exp+1.
     - If in_exp+1 == EXP_MAX: out_inf=1, mant=0.
     - Next state DONE.
  2. in_mant==0: out_zero=1, exp=0, next state DONE.
  3. in_mant[MANT_W-1]=1: next state DONE, unchanged.
  4. in_exp==0: out_denorm=1, no shift, next state DONE.
  5. Otherwise: next state NORM.
- NORM, evaluated each cycle:
  - mant[MSB]=1: next state DONE.
  - Else if exp==1: exp <= 0, out_denorm=1, next state DONE; no shift.
  - Else: mant <= mant<<1 (zero fill), exp <= exp-1, out_shift++.
  - NORM cannot loop forever: the zero case is excluded at capture, so it runs at most MANT_W-1 shift cycles.
- DONE:
  - Outputs are held stable while out_valid & !out_ready.
  - On out_ready, next state IDLE.
  - out_* retain their values until the next accept.
- Latency, accept edge E0, k left shifts:
  - k=0 or ovf/zero/denorm-at-capture: out_valid high after E0.
  - k≥1: out_valid high after edge E0+k+1.
  - Exponent floor reached after j shifts: out_valid high after E0+j+1.
- Width rules:
  - Exponent arithmetic uses EXP_W+1 bits internally to detect EXP_MAX.
  - The sticky bit never propagates left-to-right on left shifts.
- Unknown or illegal state encoding falls back to IDLE.

Decomposition:
- Shared package fpu_add_pkg:
  - state enum {IDLE, NORM, DONE}.
  - MANT_W, EXP_W, EXP_MAX constants.
  - A normalized-result struct {mant, exp, sign, shift, zero, inf, denorm}, also consumed by the rounding stage.
- No sub-module: the FSM and the single shift/decrement register path stay in one module.

Test Plan:
- Carry-out: in_ovf=1, in_mant=27'h0000003, in_exp=8'd100. Required: out_mant=27'h4000001, out_exp=101, out_shift=0, out_valid one cycle after accept.
- Left normalize: in_mant=27'h0100000 (bit 20), in_exp=8'd50. Required: 6 shifts, out_mant=27'h4000000, out_exp=44, out_shift=6, out_valid after E0+7.
- Zero and overflow:
  - in_mant=0, in_ovf=0: out_zero=1, out_exp=0.
  - in_ovf=1, in_exp=8'd254: out_inf=1, out_exp=255, out_mant=0.
- Exponent floor: in_mant=27'h0000100, in_exp=8'd4. Required: 3 shifts, out_exp=0, out_denorm=1, out_shift=3, out_mant=27'h0000800.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, and a second in_valid is not accepted until after the out_ready handshake.
  - Assert rst during NORM: out_valid=0 and in_ready=1 immediately after the asynchronous assertion, with no stale output.

Source files
------------

// File: rtl/fpu_add_pkg.sv
// Shared types and constants for the FP adder datapath: normalization FSM
// states and the normalized-result bundle handed to the rounding stage.
package fpu_add_pkg;

    localparam int MANT_W  = 27;                 // hidden bit at MANT_W-1, sticky at bit 0
    localparam int EXP_W   = 8;                  // biased exponent width
    localparam int CNT_W   = 5;                  // left-shift count width
    localparam int EXP_MAX = (1 << EXP_W) - 1;   // all-ones exponent encodes Inf

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              sign;
        logic [CNT_W-1:0]  shift;
        logic              zero;
        logic              inf;
        logic              denorm;
    } norm_res_t;

endpackage

// File: rtl/fp_add_norm_ctrl.sv
// Normalization sequencer between the significand adder and the rounder.
// A carry-out is folded in with one sticky right shift; otherwise the sum is
// shifted left one bit per cycle until the hidden bit is set or the exponent
// floor is reached. One transaction in flight at a time.
module fp_add_norm_ctrl #(
    parameter int MANT_W = fpu_add_pkg::MANT_W,
    parameter int EXP_W  = fpu_add_pkg::EXP_W,
    parameter int CNT_W  = fpu_add_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_ovf,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic [CNT_W-1:0]  out_shift,
    output logic              out_zero,
    output logic              out_inf,
    output logic              out_denorm
);
    import fpu_add_pkg::*;

    // One extra exponent bit so the carry-out increment can reach or pass EXP_MAX.
    localparam logic [EXP_W:0]   EXP_INF   = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W-1:0] EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SHIFT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [CNT_W-1:0]  shift_q, shift_d;
    logic              zero_q, zero_d;
    logic              inf_q, inf_d;
    logic              denorm_q, denorm_d;
    logic [EXP_W:0]    exp_inc;

    // Next-state and datapath: capture/classify in IDLE, shift in NORM, hold in DONE.
    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        shift_d  = shift_q;
        zero_d   = zero_q;
        inf_d    = inf_q;
        denorm_d = denorm_q;
        exp_inc  = {1'b0, in_exp} + {{EXP_W{1'b0}}, 1'b1};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_d   = in_mant;
                    exp_d    = in_exp;
                    sign_d   = in_sign;
                    shift_d  = '0;
                    zero_d   = 1'b0;
                    inf_d    = 1'b0;
                    denorm_d = 1'b0;
                    state_d  = DONE;
                    if (in_ovf) begin
                        // Saturate to Inf also when in_exp was already all-ones.
                        if (exp_inc >= EXP_INF) begin
                            inf_d  = 1'b1;
                            mant_d = '0;
                            exp_d  = EXP_INF[EXP_W-1:0];
                        end else begin
                            mant_d = {1'b1, in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
                            exp_d  = exp_inc[EXP_W-1:0];
                        end
                    end else if (in_mant == '0) begin
                        zero_d = 1'b1;
                        exp_d  = '0;
                    end else if (in_mant[MANT_W-1]) begin
                        // Already normalized: pass through untouched.
                    end else if (in_exp == '0) begin
                        denorm_d = 1'b1;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mant_q[MANT_W-1]) begin
                    state_d = DONE;
                end else if (exp_q == EXP_ONE) begin
                    // Floor reached: drop to the denormal exponent without shifting.
                    exp_d    = '0;
                    denorm_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    // Zero fill; the sticky bit only ever moves towards the MSB.
                    mant_d  = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d   = exp_q - EXP_ONE;
                    shift_d = shift_q + SHIFT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            shift_q  <= '0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            shift_q  <= shift_d;
            zero_q   <= zero_d;
            inf_q    <= inf_d;
            denorm_q <= denorm_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_mant   = mant_q;
    assign out_exp    = exp_q;
    assign out_sign   = sign_q;
    assign out_shift  = shift_q;
    assign out_zero   = zero_q;
    assign out_inf    = inf_q;
    assign out_denorm = denorm_q;

endmodule

// File: tb/tb_fp_add_norm_ctrl.sv
// Testbench for fp_add_norm_ctrl: directed cases plus a reference model,
// with a scoreboard monitor that checks every output handshake.
module tb_fp_add_norm_ctrl;

    localparam int MW = 27;
    localparam int EW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] in_mant = '0;
    logic          in_ovf = 1'b0;
    logic [EW-1:0] in_exp = '0;
    logic          in_sign = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [MW-1:0] out_mant;
    logic [EW-1:0] out_exp;
    logic          out_sign;
    logic [CW-1:0] out_shift;
    logic          out_zero;
    logic          out_inf;
    logic          out_denorm;

    fp_add_norm_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_ovf     (in_ovf),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_sign   (out_sign),
        .out_shift  (out_shift),
        .out_zero   (out_zero),
        .out_inf    (out_inf),
        .out_denorm (out_denorm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int txn        = 0;

    typedef struct {
        logic [MW-1:0] mant;
        logic [EW-1:0] exp;
        logic          sign;
        logic [CW-1:0] shift;
        logic          zero;
        logic          inf;
        logic          denorm;
        int            lat;   // cycles from accept edge to the handshake sample
        int            acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic exp_t mk(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic s,
                                input logic [CW-1:0] sh, input logic z, input logic i,
                                input logic d, input int lat);
        exp_t r;
        r.mant = m; r.exp = e; r.sign = s; r.shift = sh;
        r.zero = z; r.inf = i; r.denorm = d; r.lat = lat; r.acc = 0;
        return r;
    endfunction

    // Reference behaviour computed arithmetically (leading-zero count, not per-cycle).
    function automatic exp_t ref_model(input logic [MW-1:0] m, input logic ovf,
                                       input logic [EW-1:0] e, input logic s);
        exp_t r;
        int   lz;
        int   ex;
        r = mk(m, e, s, '0, 1'b0, 1'b0, 1'b0, 0);
        if (ovf) begin
            ex = int'(e) + 1;
            if (ex >= 255) begin
                r.inf = 1'b1; r.mant = '0; r.exp = 8'd255;
            end else begin
                r.mant = (m >> 1) | {26'd0, m[0]} | 27'h4000000;
                r.exp  = 8'(ex);
            end
        end else if (m == '0) begin
            r.zero = 1'b1; r.exp = '0;
        end else if (m[MW-1]) begin
            r.lat = 0;
        end else if (e == '0) begin
            r.denorm = 1'b1;
        end else begin
            lz = 0;
            while (!m[MW-1-lz]) lz++;
            if (int'(e) > lz) begin
                r.mant  = m << lz;
                r.exp   = e - 8'(lz);
                r.shift = 5'(lz);
                r.lat   = lz + 1;
            end else begin
                r.mant   = m << (e - 8'd1);
                r.exp    = '0;
                r.denorm = 1'b1;
                r.shift  = 5'(int'(e) - 1);
                r.lat    = int'(e);
            end
        end
        return r;
    endfunction

    // Scoreboard monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            txn++;
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output: got mant=%h exp=%0d, required no output", out_mant, out_exp);
            end else begin
                mon_e = sb.pop_front();
                if (out_mant !== mon_e.mant || out_exp !== mon_e.exp || out_sign !== mon_e.sign ||
                    out_shift !== mon_e.shift || out_zero !== mon_e.zero ||
                    out_inf !== mon_e.inf || out_denorm !== mon_e.denorm) begin
                    mismatched++;
                    $display("FAIL txn%0d_result: got mant=%h exp=%0d s=%0b sh=%0d z=%0b i=%0b d=%0b, required mant=%h exp=%0d s=%0b sh=%0d z=%0b i=%0b d=%0b",
                             txn, out_mant, out_exp, out_sign, out_shift, out_zero, out_inf, out_denorm,
                             mon_e.mant, mon_e.exp, mon_e.sign, mon_e.shift, mon_e.zero, mon_e.inf, mon_e.denorm);
                end
                compared++;
                if ((cyc - mon_e.acc) !== mon_e.lat) begin
                    mismatched++;
                    $display("FAIL txn%0d_latency: got %0d, required %0d", txn, cyc - mon_e.acc, mon_e.lat);
                end
                $display("txn %0d: mant=%h exp=%0d sign=%0b shift=%0d zero=%0b inf=%0b denorm=%0b lat=%0d",
                         txn, out_mant, out_exp, out_sign, out_shift, out_zero, out_inf, out_denorm, cyc - mon_e.acc);
            end
        end
    end

    // Waits for in_ready, presents one operand and optionally records the expectation.
    task automatic send(input logic [MW-1:0] m, input logic ovf, input logic [EW-1:0] e,
                        input logic s, input bit push, input exp_t ex);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        compared++;
        if (w >= 200) begin
            mismatched++;
            $display("FAIL send_ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
        end
        in_mant = m; in_ovf = ovf; in_exp = e; in_sign = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            ex.acc = cyc;
            sb.push_back(ex);
        end
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: got %0d outstanding results, required 0", name, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_handshake: got out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
        end
        compared++;
        if (out_mant !== '0 || out_exp !== '0 || out_shift !== '0 || out_sign !== 1'b0 ||
            out_zero !== 1'b0 || out_inf !== 1'b0 || out_denorm !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got mant=%h exp=%0d shift=%0d, required all zero", out_mant, out_exp, out_shift);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: got in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_carry;
        send(27'h0000003, 1'b1, 8'd100, 1'b0, 1'b1, mk(27'h4000001, 8'd101, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 0));
        send(27'h7FFFFFE, 1'b1, 8'd20, 1'b1, 1'b1, mk(27'h7FFFFFF, 8'd21, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 0));
        drain("carry");
    endtask

    task automatic test_left_norm;
        send(27'h0100000, 1'b0, 8'd50, 1'b1, 1'b1, mk(27'h4000000, 8'd44, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 7));
        // Low bits must not smear: 3 << 25 with zero fill.
        send(27'h0000003, 1'b0, 8'd100, 1'b0, 1'b1, mk(27'h6000000, 8'd75, 1'b0, 5'd25, 1'b0, 1'b0, 1'b0, 26));
        drain("left_norm");
    endtask

    task automatic test_zero_inf;
        send(27'h0000000, 1'b0, 8'd77, 1'b0, 1'b1, mk(27'h0, 8'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 0));
        send(27'h1234567, 1'b1, 8'd254, 1'b1, 1'b1, mk(27'h0, 8'd255, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 0));
        drain("zero_inf");
    endtask

    task automatic test_floor;
        send(27'h0000100, 1'b0, 8'd4, 1'b0, 1'b1, mk(27'h0000800, 8'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 4));
        // Hidden bit lands exactly when exp reaches 1: normal, not denormal.
        send(27'h0800000, 1'b0, 8'd4, 1'b1, 1'b1, mk(27'h4000000, 8'd1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 4));
        send(27'h0001000, 1'b0, 8'd0, 1'b0, 1'b1, mk(27'h0001000, 8'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 0));
        send(27'h4000123, 1'b0, 8'd9, 1'b1, 1'b1, mk(27'h4000123, 8'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 0));
        drain("floor");
    endtask

    task automatic test_backpressure;
        int w;
        exp_t dummy;
        dummy = mk('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
        out_ready = 1'b0;
        send(27'h0100000, 1'b0, 8'd50, 1'b0, 1'b1, mk(27'h4000000, 8'd44, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 13));
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        compared++;
        if (w !== 7) begin
            mismatched++;
            $display("FAIL bp_first_valid: got %0d cycles, required 7", w);
        end
        // Offer a second operand while the first result is stalled.
        in_mant = 27'h4000123; in_ovf = 1'b0; in_exp = 8'd77; in_sign = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mant !== 27'h4000000 ||
                out_exp !== 8'd44 || out_shift !== 5'd6) begin
                mismatched++;
                $display("FAIL bp_hold_%0d: got valid=%0b ready=%0b mant=%h exp=%0d sh=%0d, required 1/0/4000000/44/6",
                         i, out_valid, in_ready, out_mant, out_exp, out_shift);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mant !== 27'h4000000) begin
            mismatched++;
            $display("FAIL bp_after_handshake: got ready=%0b valid=%0b mant=%h, required 1/0/4000000",
                     in_ready, out_valid, out_mant);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dummy = mk(27'h4000123, 8'd77, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 0);
        dummy.acc = cyc;
        sb.push_back(dummy);
        drain("backpressure");
    endtask

    task automatic test_reset_mid_norm;
        int seen;
        exp_t dummy;
        dummy = mk('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
        send(27'h0000001, 1'b0, 8'd100, 1'b1, 1'b0, dummy);
        repeat (3) @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_pre_norm: got valid=%0b ready=%0b, required 0/0", out_valid, in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_async_handshake: got valid=%0b ready=%0b, required 0/1", out_valid, in_ready);
        end
        compared++;
        if (out_mant !== '0 || out_exp !== '0 || out_shift !== '0 || out_sign !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_async_outputs: got mant=%h exp=%0d sh=%0d sign=%0b, required all zero",
                     out_mant, out_exp, out_shift, out_sign);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL rst_no_stale_output: got %0d valid cycles, required 0", seen);
        end
        send(27'h0200000, 1'b0, 8'd30, 1'b0, 1'b1, mk(27'h4000000, 8'd25, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 6));
        drain("rst_recover");
    endtask

    task automatic test_back_to_back;
        logic [MW-1:0] m;
        logic          ovf;
        logic [EW-1:0] e;
        logic          s;
        for (int i = 0; i < 16; i++) begin
            m   = 27'($urandom) >> $urandom_range(0, 26);
            ovf = ($urandom_range(0, 3) == 0);
            e   = 8'($urandom_range(0, 255));
            s   = 1'($urandom_range(0, 1));
            send(m, ovf, e, s, 1'b1, ref_model(m, ovf, e, s));
        end
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_carry();
        test_left_norm();
        test_zero_inf();
        test_floor();
        test_backpressure();
        test_reset_mid_norm();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
